pc_fetch: RTL

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/nano_pkg.sv | 40 ++++
 rtl/pc_next.sv | 29 ++
 rtl/pc_fetch.sv | 112 +++++++++++
 3 files changed

// File: rtl/nano_pkg.sv
// Shared definitions for the nano CPU: widths, instruction field positions,
// opcodes and the fetch FSM encoding used by both fetch unit and controller.
package nano_pkg;

    localparam int PC_W = 8;
    localparam int IR_W = 16;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RA_MSB  = 11;
    localparam int RA_LSB  = 10;
    localparam int RB_MSB  = 9;
    localparam int RB_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Number of WAIT cycles tolerated before a read is declared lost.
    localparam int WAIT_LIMIT = 15;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LD  = 4'h1,
        OP_ST  = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_LDI = 4'h7,
        OP_JMP = 4'h8,
        OP_BEQ = 4'h9,
        OP_BNE = 4'hA
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: absolute jump, PC-relative branch or
// sequential increment, all wrapping modulo 2**PC_W.
module pc_next
    import nano_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] imm_i,
    input  logic            sel_jmp_i,
    input  logic            sel_desv_i,
    output logic [PC_W-1:0] pc_next_o
);

    logic        [PC_W-1:0] pc_inc;
    logic signed [PC_W-1:0] offset;

    assign pc_inc = pc_i + PC_W'(1);
    // Offset and PC share a width, so sign-extension wraps for free.
    assign offset = signed'(imm_i);

    always_comb begin
        pc_next_o = pc_inc;
        if (sel_jmp_i) begin
            pc_next_o = imm_i;
        end else if (sel_desv_i) begin
            pc_next_o = pc_inc + PC_W'(offset);
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch unit: owns PC and IR, issues memory reads, waits for
// acknowledge with a bounded timeout, and presents decoded IR fields.
module pc_fetch
    import nano_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             LdPC,
    input  logic             SelJMP,
    input  logic             SelDesv,
    output logic [PC_W-1:0]  imem_addr,
    output logic             imem_rd,
    input  logic [IR_W-1:0]  imem_data,
    input  logic             imem_ack,
    output logic [3:0]       OP,
    output logic [1:0]       RegA,
    output logic [1:0]       RegB,
    output logic [7:0]       Imm,
    output logic [PC_W-1:0]  PC,
    output logic             instr_valid,
    output logic             fetch_err
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_nxt;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic            err_q, err_d;
    logic            stall_q, stall_d;

    pc_next u_pc_next (
        .pc_i       (pc_q),
        .imm_i      (ir_q[IMM_MSB:IMM_LSB]),
        .sel_jmp_i  (SelJMP),
        .sel_desv_i (SelDesv),
        .pc_next_o  (pc_nxt)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        stall_d = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                // A stalled FETCH cycle keeps imem_rd low, so any ack is ignored.
                if (!stall_q) begin
                    if (imem_ack) begin
                        ir_d    = imem_data;
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    wcnt_d  = '0;
                    state_d = ST_READY;
                end else if (wcnt_q == 4'(WAIT_LIMIT - 1)) begin
                    err_d   = 1'b1;
                    stall_d = 1'b1;
                    wcnt_d  = '0;
                    state_d = ST_FETCH;
                end else begin
                    wcnt_d  = wcnt_q + 4'd1;
                end
            end
            ST_READY: begin
                if (LdPC) begin
                    pc_d    = pc_nxt;
                    wcnt_d  = '0;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Reset leaves one idle cycle (stall) so the abandoned read is not re-acked.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign imem_rd     = (state_q != ST_READY) && !stall_q;
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign instr_valid = (state_q == ST_READY);
    assign fetch_err   = err_q;
    assign OP          = ir_q[OP_MSB:OP_LSB];
    assign RegA        = ir_q[RA_MSB:RA_LSB];
    assign RegB        = ir_q[RB_MSB:RB_LSB];
    assign Imm         = ir_q[IMM_MSB:IMM_LSB];

endmodule
